rate_divider: RTL
=================

Name: rate_divider

Overview:
- Upstream pacing stage for the 8-bit display counter.
- Divides the board clock into single-cycle enable pulses (Tick) at a switch-selected rate.
- Tick drives the counter's Enable input, so the counter advances visibly instead of every clock edge.
- Shares Clk with the counter; has its own synchronous active-low clear.

Parameters:
- CNT_W, 28, width of internal down-counter; must hold DIV3-1.
- DIV1, 50000000, period in clocks for Speed=1 (1 Hz at 50 MHz).
- DIV2, 100000000, period in clocks for Speed=2 (0.5 Hz).
- DIV3, 200000000, period in clocks for Speed=3 (0.25 Hz).
- Speed=0 period is fixed at 1 (full rate). All DIVn >= 1.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Clear_b  input  1  reset, synchronous, active-low.
- Enable  input  1  run/pause; when 0, divider freezes.
- Speed  input  2  rate select (0: every clock, 1: DIV1, 2: DIV2, 3: DIV3).
- Tick  output  1  one-cycle pulse, registered; feeds counter Enable.
- Sel  output  2  speed setting currently in effect (registered).

Behaviour:
- Single clock Clk; reset is synchronous and active-low (Clear_b sampled on posedge Clk only); no asynchronous paths.
- PERIOD(s): 1, DIV1, DIV2, DIV3 for s = 0..3.
- Reset (Clear_b=0 at edge):
  - Sel <= Speed.
  - cnt <= PERIOD(Speed)-1.
  - Tick <= 0.
  - Reset has priority over all else, including mid-period.
- Enable=0, not in reset: cnt and Sel hold; Tick <= 0.
- Enable=1, cnt != 0: cnt <= cnt-1; Tick <= 0.
- Enable=1, cnt == 0 (wrap):
  - Tick <= 1.
  - Sel <= Speed.
  - cnt <= PERIOD(Speed)-1.
  - The new rate is sampled at the wrap.
- Latency:
  - After reset release with Enable held 1, the first Tick is high in the cycle after the PERIOD(Sel)-th enabled edge.
  - Subsequent Ticks repeat every PERIOD(Sel) enabled edges.
- Speed=0: cnt is always 0, so Tick is high on every cycle following an enabled edge; continuous 1 while Enable is held 1.
- Pause mid-period preserves the remaining count; resuming continues without losing or adding cycles.
- Tick is never high for two consecutive cycles unless PERIOD=1.
- Width: cnt is CNT_W bits unsigned; decrement never underflows because 0 always reloads.
- Speed change mid-period (default build): ignored until the next wrap; Sel shows the old value until then.

Optional Feature:
- Macro: RATE_DIV_LIVE_RELOAD_EN.
- Defined:
  - Each non-reset edge compares Speed against Sel.
  - If they differ, the edge does: Sel <= Speed; cnt <= PERIOD(Speed)-1; Tick <= 0.
  - This applies regardless of Enable, and takes priority over countdown and wrap.
  - A new rate therefore takes effect immediately with a full fresh period.
- Not defined: Speed is sampled only at reset and wrap, as in Behaviour.

Test Plan (DIV1=4, DIV2=8, DIV3=16, CNT_W=5):
- Clear_b=0 for 2 edges, Speed=1, Enable=1, then release -> Tick=0 during reset; first Tick after the 4th enabled edge; then every 4 edges, width 1 cycle; Sel=1.
- Speed=0, Enable=1 after reset -> Tick=1 every cycle after the first edge; Sel=0.
- Speed=2: enable 3 edges, Enable=0 for 10 edges, Enable=1 -> Tick stays 0 while paused; Tick after 5 more enabled edges (8 total).
- Speed=3 running, switch Speed to 1 after 5 edges -> default build: next Tick after 16 edges, then Sel=1 and period 4. With RATE_DIV_LIVE_RELOAD_EN: Sel=1 next edge, Tick 4 edges later.
- Speed=1, assert Clear_b=0 one edge when cnt=1 -> Tick stays 0, cnt reloads to 3; next Tick 4 enabled edges after release.
- Chain Tick into the 8-bit counter's Enable, Speed=1, run 1024 edges -> counter reads 0x00 after 256 ticks (wrap); HEX1:HEX0 advance once per 4 clocks.

Source files
------------

// File: rtl/rate_divider.sv
// rate_divider: divides Clk into single-cycle Tick enable pulses at a
// Speed-selected rate (every clock, DIV1, DIV2 or DIV3 clocks per Tick).
// Tick is meant to drive the display counter's Enable input.
//
// Optional build macro: RATE_DIV_LIVE_RELOAD_EN
//   undefined : Speed is sampled only at clear and at each wrap.
//   defined   : any mismatch between Speed and Sel reloads immediately
//               with a fresh full period, regardless of Enable.
//
// The remaining count is a down-counter; terminal count 0 produces the Tick
// and reloads PERIOD(Speed)-1, so the counter never underflows.

module rate_divider #(
   parameter int CNT_W = 28,
   parameter int DIV1  = 50000000,
   parameter int DIV2  = 100000000,
   parameter int DIV3  = 200000000
) (
   input  logic       Clk,
   input  logic       Clear_b,
   input  logic       Enable,
   input  logic [1:0] Speed,
   output logic       Tick,
   output logic [1:0] Sel
);

   localparam logic [CNT_W-1:0] RLD1 = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] RLD2 = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] RLD3 = CNT_W'(DIV3 - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sel;
   logic             r_tick;

   logic [CNT_W-1:0] w_reload;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_sel_nxt;
   logic             w_tick_nxt;

   // Reload value for the rate currently requested on Speed (PERIOD-1).
   always_comb begin
      w_reload = '0;
      case (Speed)
         2'd1:    w_reload = RLD1;
         2'd2:    w_reload = RLD2;
         2'd3:    w_reload = RLD3;
         default: w_reload = '0;
      endcase
   end

   // Next-state: clear first, then (optionally) live reload, then pause,
   // wrap, or plain countdown. Tick defaults low so it is always one cycle.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_sel_nxt  = r_sel;
      w_tick_nxt = 1'b0;
      if (!Clear_b) begin
         w_sel_nxt = Speed;
         w_cnt_nxt = w_reload;
      end
`ifdef RATE_DIV_LIVE_RELOAD_EN
      else if (Speed != r_sel) begin
         w_sel_nxt = Speed;
         w_cnt_nxt = w_reload;
      end
`endif
      else if (Enable) begin
         if (r_cnt == '0) begin
            w_tick_nxt = 1'b1;
            w_sel_nxt  = Speed;
            w_cnt_nxt  = w_reload;
         end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
         end
      end
   end

   // State register; the clear is folded into the next-state logic above,
   // so it is purely synchronous.
   always_ff @(posedge Clk) begin
      r_cnt  <= w_cnt_nxt;
      r_sel  <= w_sel_nxt;
      r_tick <= w_tick_nxt;
   end

   assign Tick = r_tick;
   assign Sel  = r_sel;

endmodule
